lbp_hist: RTL and testbench
===========================

LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 Parameter DATA_WIDTH, default 8: LBP code width; the histogram has 2**DATA_WIDTH bins.
REQ-002 Parameter ADDR_WIDTH, default 14: LBP pixel address width.
REQ-003 Parameter CNT_WIDTH, default 14: bin counter and pixel counter width.
REQ-004 clk  input  1  single clock; all flops update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 lbp_valid  input  1  one LBP code is presented this cycle.
REQ-007 lbp_addr  input  ADDR_WIDTH  pixel address of the code; not used for binning, not checked.
REQ-008 lbp_data  input  DATA_WIDTH  LBP code, used as the bin index.
REQ-009 finish  input  1  level from the upstream LBP stage; the frame is complete.
REQ-010 hist_valid  output  1  hist_bin/hist_count hold a valid readout word.
REQ-011 hist_ready  input  1  downstream accepts the word when hist_valid && hist_ready.
REQ-012 hist_bin  output  DATA_WIDTH  bin index of the current readout word.
REQ-013 hist_count  output  CNT_WIDTH  count of that bin.
REQ-014 pix_cnt  output  CNT_WIDTH  total codes accumulated this frame, saturating.
REQ-015 hist_done  output  1  high once all bins have been accepted.

Function
REQ-016 The FSM SHALL have three states: ACCUM, DUMP and DONE; ACCUM is the reset state.
REQ-017 In ACCUM, each cycle with lbp_valid=1 SHALL increment bin[lbp_data] and pix_cnt by 1 at the next edge; back-to-back valids SHALL be counted every cycle, with no stall.
REQ-018 Bin and pix_cnt increments SHALL saturate at 2**CNT_WIDTH-1 and never wrap.
REQ-019 ACCUM SHALL go to DUMP on the edge where finish=1; a lbp_valid in that same cycle SHALL still be counted.
REQ-020 In DUMP, hist_valid SHALL be 1 and hist_bin SHALL start at 0; hist_count SHALL equal bin[hist_bin] combinationally from the registered array.
REQ-021 hist_bin SHALL advance by 1 only on a cycle with hist_valid && hist_ready; while hist_ready=0, hist_bin and hist_count SHALL be held stable.
REQ-022 Acceptance of bin 2**DATA_WIDTH-1 SHALL move the FSM to DONE on the next edge; hist_valid SHALL drop in that same edge.
REQ-023 DONE SHALL be terminal until reset: hist_done=1, hist_valid=0.
REQ-024 lbp_valid SHALL be ignored in DUMP and DONE; bins and pix_cnt SHALL be frozen.
REQ-025 finish deasserting in DUMP or DONE SHALL have no effect.
REQ-026 Latency: the first readout word SHALL be valid 1 cycle after finish is sampled; a full dump with hist_ready held at 1 SHALL take 2**DATA_WIDTH cycles.

Reset
REQ-027 Reset SHALL set the state to ACCUM and clear all bins and pix_cnt to 0.
REQ-028 Reset SHALL set hist_bin to 0, hist_valid to 0 and hist_done to 0.
REQ-029 Reset SHALL take priority over every input, including mid-ACCUM and mid-DUMP; the next cycle behaves as a fresh frame.

Structure
REQ-030 DATA_WIDTH, ADDR_WIDTH, CNT_WIDTH and the state encodings SHALL live in the shared LBP package used by the LBP stage.
REQ-031 The bin array SHALL be a flop array inside lbp_hist.
REQ-032 One sub-module, sat_inc (a parameterised saturating incrementer), SHALL be used for both bin and pix_cnt updates.

Verification
REQ-033 Reset, then 5 valids of code 0x3C, then finish, hist_ready=1 -> hist_count=5 at bin 0x3C, 0 at all other bins, pix_cnt=5, hist_done after 256 words.
REQ-034 Stream of 15876 valids (126x126 frame) with codes i mod 256 -> pix_cnt=15876; bins 0..3=63, bins 4..255=62; sum of dumped counts=15876.
REQ-035 lbp_valid and finish both high in the same cycle, code 0xFF -> bin 0xFF=1; later valids ignored.
REQ-036 hist_ready toggled randomly during DUMP -> each bin 0..255 accepted exactly once, in order, with stable data while stalled.
REQ-037 With CNT_WIDTH=4, 20 valids of code 7 -> bin 7=15, pix_cnt=15.
REQ-038 Reset asserted at bin 100 during DUMP -> the next cycle is ACCUM with all bins 0, hist_valid=0 and hist_done=0.

Source files
------------

// File: rtl/lbp_hist_pkg.sv
// Shared LBP package: default widths and the histogram FSM state encoding.
package lbp_hist_pkg;

  localparam int LBP_DATA_WIDTH = 8;   // LBP code width; 2**W histogram bins
  localparam int LBP_ADDR_WIDTH = 14;  // pixel address width
  localparam int LBP_CNT_WIDTH  = 14;  // bin / pixel counter width

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DUMP  = 2'd1,
    ST_DONE  = 2'd2
  } hist_state_e;

endpackage

// File: rtl/lbp_hist_sat_inc.sv
// Saturating incrementer: adds one when asked, sticks at all-ones.
module sat_inc #(
  parameter int W = 14
) (
  input  logic [W-1:0] val_i,
  input  logic         inc_i,
  output logic [W-1:0] val_o
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

  // Increment unless already at the ceiling.
  always_comb begin
    if (inc_i && (val_i != MAX_VAL)) begin
      val_o = val_i + W'(1);
    end else begin
      val_o = val_i;
    end
  end

endmodule

// File: rtl/lbp_hist.sv
// LBP histogram: accumulates codes into a flop-array histogram, then streams
// every bin out over a valid/ready port once the frame is finished.
module lbp_hist
  import lbp_hist_pkg::*;
#(
  parameter int DATA_WIDTH = LBP_DATA_WIDTH,
  parameter int ADDR_WIDTH = LBP_ADDR_WIDTH,
  parameter int CNT_WIDTH  = LBP_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lbp_valid,
  input  logic [ADDR_WIDTH-1:0] lbp_addr,
  input  logic [DATA_WIDTH-1:0] lbp_data,
  input  logic                  finish,
  output logic                  hist_valid,
  input  logic                  hist_ready,
  output logic [DATA_WIDTH-1:0] hist_bin,
  output logic [CNT_WIDTH-1:0]  hist_count,
  output logic [CNT_WIDTH-1:0]  pix_cnt,
  output logic                  hist_done
);

  localparam int NBINS = 2 ** DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] LAST_BIN = {DATA_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0]  bins_q [NBINS];
  hist_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] hist_bin_q, hist_bin_d;
  logic                  hist_valid_q, hist_valid_d;
  logic                  hist_done_q, hist_done_d;
  logic [CNT_WIDTH-1:0]  pix_cnt_q, pix_cnt_d;

  logic                  count_s;
  logic [CNT_WIDTH-1:0]  bin_sel_s;
  logic [CNT_WIDTH-1:0]  bin_inc_s;
  logic                  addr_unused_s;

  // The pixel address travels with the code but plays no part in binning.
  assign addr_unused_s = ^lbp_addr;

  // Codes are only counted while accumulating; DUMP/DONE freeze the histogram.
  assign count_s   = (state_q == ST_ACCUM) && lbp_valid;
  assign bin_sel_s = bins_q[lbp_data];

  sat_inc #(.W(CNT_WIDTH)) u_bin_inc (
    .val_i (bin_sel_s),
    .inc_i (count_s),
    .val_o (bin_inc_s)
  );

  sat_inc #(.W(CNT_WIDTH)) u_pix_inc (
    .val_i (pix_cnt_q),
    .inc_i (count_s),
    .val_o (pix_cnt_d)
  );

  // Next-state and readout control for the ACCUM -> DUMP -> DONE sequence.
  always_comb begin
    state_d      = state_q;
    hist_bin_d   = hist_bin_q;
    hist_valid_d = hist_valid_q;
    hist_done_d  = hist_done_q;
    case (state_q)
      ST_ACCUM: begin
        if (finish) begin
          state_d      = ST_DUMP;
          hist_bin_d   = '0;
          hist_valid_d = 1'b1;
          hist_done_d  = 1'b0;
        end else begin
          hist_valid_d = 1'b0;
          hist_done_d  = 1'b0;
        end
      end
      ST_DUMP: begin
        if (hist_ready) begin
          if (hist_bin_q == LAST_BIN) begin
            state_d      = ST_DONE;
            hist_valid_d = 1'b0;
            hist_done_d  = 1'b1;
          end else begin
            hist_bin_d   = hist_bin_q + DATA_WIDTH'(1);
          end
        end else begin
          hist_bin_d = hist_bin_q;
        end
      end
      ST_DONE: begin
        hist_valid_d = 1'b0;
        hist_done_d  = 1'b1;
      end
      default: begin
        state_d      = ST_ACCUM;
        hist_bin_d   = '0;
        hist_valid_d = 1'b0;
        hist_done_d  = 1'b0;
      end
    endcase
  end

  // FSM state, readout registers and pixel counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ACCUM;
      hist_bin_q   <= '0;
      hist_valid_q <= 1'b0;
      hist_done_q  <= 1'b0;
      pix_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      hist_bin_q   <= hist_bin_d;
      hist_valid_q <= hist_valid_d;
      hist_done_q  <= hist_done_d;
      pix_cnt_q    <= pix_cnt_d;
    end
  end

  // Histogram bin array: one saturating update per accepted code.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBINS; i++) begin
        bins_q[i] <= '0;
      end
    end else if (count_s) begin
      bins_q[lbp_data] <= bin_inc_s;
    end
  end

  assign hist_valid = hist_valid_q;
  assign hist_bin   = hist_bin_q;
  assign hist_count = bins_q[hist_bin_q];
  assign pix_cnt    = pix_cnt_q;
  assign hist_done  = hist_done_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: frame accumulation, dump handshake,
// saturation and mid-dump reset.
module tb_lbp_hist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-width instance
  logic        reset = 1'b1;
  logic        lbp_valid = 1'b0;
  logic [13:0] lbp_addr = '0;
  logic [7:0]  lbp_data = '0;
  logic        finish = 1'b0;
  logic        hist_valid;
  logic        hist_ready = 1'b0;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count;
  logic [13:0] pix_cnt;
  logic        hist_done;

  // Narrow instance for saturation
  logic        r4 = 1'b1;
  logic        v4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [2:0]  d4 = '0;
  logic        f4 = 1'b0;
  logic        val4;
  logic        rdy4 = 1'b0;
  logic [2:0]  bin4;
  logic [3:0]  cnt4;
  logic [3:0]  pix4;
  logic        done4;

  lbp_hist dut (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .hist_valid(hist_valid),
    .hist_ready(hist_ready), .hist_bin(hist_bin), .hist_count(hist_count),
    .pix_cnt(pix_cnt), .hist_done(hist_done)
  );

  lbp_hist #(.DATA_WIDTH(3), .ADDR_WIDTH(4), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(r4), .lbp_valid(v4), .lbp_addr(a4),
    .lbp_data(d4), .finish(f4), .hist_valid(val4),
    .hist_ready(rdy4), .hist_bin(bin4), .hist_count(cnt4),
    .pix_cnt(pix4), .hist_done(done4)
  );

  typedef struct {
    int frame;
    int bin;
    int cnt;
  } vec_t;

  vec_t tbl [17];
  int   total = 0;
  int   bad = 0;
  int   dump_cnt [256];
  int   dump4 [8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    lbp_valid = 1'b0;
    finish = 1'b0;
    hist_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic send(input int code);
    lbp_valid = 1'b1;
    lbp_data = 8'(code);
    step();
    lbp_valid = 1'b0;
  endtask

  function automatic int dump_sum();
    int s = 0;
    for (int i = 0; i < 256; i++) s += dump_cnt[i];
    return s;
  endfunction

  // Drain the histogram; optionally random ready and junk on the input side.
  task automatic dump_all(input bit rnd, input bit noise, input int exp_cycles);
    int   idx = 0;
    int   cyc = 0;
    bit   stalled = 1'b0;
    int   sbin = 0;
    int   scnt = 0;
    for (int i = 0; i < 256; i++) dump_cnt[i] = -1;
    while (!hist_done && cyc < 3000) begin
      if (hist_valid) begin
        if (stalled) begin
          check("stall_bin", int'(hist_bin), sbin);
          check("stall_cnt", int'(hist_count), scnt);
        end
        hist_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (hist_ready) begin
          check("order", int'(hist_bin), idx);
          dump_cnt[hist_bin] = int'(hist_count);
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          sbin = int'(hist_bin);
          scnt = int'(hist_count);
        end
      end else begin
        hist_ready = 1'b0;
      end
      if (noise) begin
        lbp_valid = 1'($urandom_range(0, 1));
        lbp_data  = 8'($urandom_range(0, 255));
        finish    = 1'($urandom_range(0, 1));
      end
      step();
      cyc++;
    end
    lbp_valid = 1'b0;
    finish = 1'b0;
    hist_ready = 1'b0;
    check("dump_words", idx, 256);
    check("dump_done", int'(hist_done), 1);
    check("dump_valid_low", int'(hist_valid), 0);
    if (exp_cycles > 0) check("dump_cycles", cyc, exp_cycles);
  endtask

  task automatic check_table(input int fr);
    int act;
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].frame == fr) begin
        act = (fr == 5) ? dump4[tbl[i].bin] : dump_cnt[tbl[i].bin];
        check($sformatf("f%0d_bin%0d", fr, tbl[i].bin), act, tbl[i].cnt);
      end
    end
  endtask

  initial begin
    int cyc;
    tbl[0]  = '{1, 8'h3C, 5};
    tbl[1]  = '{1, 0, 0};
    tbl[2]  = '{1, 8'h3B, 0};
    tbl[3]  = '{1, 8'h3D, 0};
    tbl[4]  = '{1, 255, 0};
    tbl[5]  = '{2, 0, 63};
    tbl[6]  = '{2, 3, 63};
    tbl[7]  = '{2, 4, 62};
    tbl[8]  = '{2, 255, 62};
    tbl[9]  = '{3, 255, 1};
    tbl[10] = '{3, 0, 0};
    tbl[11] = '{3, 16, 0};
    tbl[12] = '{4, 100, 0};
    tbl[13] = '{4, 5, 1};
    tbl[14] = '{5, 7, 15};
    tbl[15] = '{5, 0, 0};
    tbl[16] = '{5, 6, 0};

    // Frame 1: five codes of 0x3C
    do_reset();
    check("rst_valid", int'(hist_valid), 0);
    check("rst_done", int'(hist_done), 0);
    check("rst_pix", int'(pix_cnt), 0);
    check("rst_bin", int'(hist_bin), 0);
    for (int i = 0; i < 5; i++) send(8'h3C);
    check("f1_pix_pre", int'(pix_cnt), 5);
    finish = 1'b1;
    step();
    finish = 1'b0;
    check("f1_latency_valid", int'(hist_valid), 1);
    check("f1_first_bin", int'(hist_bin), 0);
    dump_all(1'b0, 1'b0, 256);
    check("f1_sum", dump_sum(), 5);
    check("f1_pix", int'(pix_cnt), 5);
    check_table(1);
    lbp_valid = 1'b1;
    lbp_data = 8'h3C;
    finish = 1'b1;
    for (int i = 0; i < 4; i++) step();
    lbp_valid = 1'b0;
    finish = 1'b0;
    step();
    check("f1_done_hold", int'(hist_done), 1);
    check("f1_valid_hold", int'(hist_valid), 0);
    check("f1_pix_frozen", int'(pix_cnt), 5);

    // Frame 2: 126x126 frame, codes i mod 256, back to back
    do_reset();
    lbp_valid = 1'b1;
    for (int i = 0; i < 15876; i++) begin
      lbp_data = 8'(i);
      step();
    end
    lbp_valid = 1'b0;
    check("f2_pix", int'(pix_cnt), 15876);
    finish = 1'b1;
    step();
    finish = 1'b0;
    dump_all(1'b0, 1'b0, 256);
    check("f2_sum", dump_sum(), 15876);
    check_table(2);

    // Frame 3: valid and finish together, then random ready with input noise
    do_reset();
    lbp_valid = 1'b1;
    lbp_data = 8'hFF;
    finish = 1'b1;
    step();
    lbp_valid = 1'b0;
    finish = 1'b0;
    check("f3_valid", int'(hist_valid), 1);
    check("f3_pix_pre", int'(pix_cnt), 1);
    dump_all(1'b1, 1'b1, 0);
    check("f3_pix", int'(pix_cnt), 1);
    check("f3_sum", dump_sum(), 1);
    check_table(3);

    // Frame 4: reset while bin 100 is on the port
    do_reset();
    for (int i = 0; i < 3; i++) send(100);
    finish = 1'b1;
    step();
    finish = 1'b0;
    hist_ready = 1'b1;
    cyc = 0;
    while (hist_bin != 8'd100 && cyc < 300) begin
      step();
      cyc++;
    end
    check("f4_reach100", int'(hist_bin), 100);
    check("f4_cnt100", int'(hist_count), 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    hist_ready = 1'b0;
    check("f4_rst_valid", int'(hist_valid), 0);
    check("f4_rst_done", int'(hist_done), 0);
    check("f4_rst_pix", int'(pix_cnt), 0);
    check("f4_rst_bin", int'(hist_bin), 0);
    send(5);
    check("f4_pix", int'(pix_cnt), 1);
    finish = 1'b1;
    step();
    finish = 1'b0;
    dump_all(1'b0, 1'b0, 256);
    check("f4_sum", dump_sum(), 1);
    check_table(4);

    // Frame 5: counter saturation on the 4-bit instance
    for (int i = 0; i < 8; i++) dump4[i] = -1;
    r4 = 1'b0;
    v4 = 1'b1;
    d4 = 3'd7;
    for (int i = 0; i < 20; i++) step();
    v4 = 1'b0;
    check("f5_pix", int'(pix4), 15);
    f4 = 1'b1;
    step();
    f4 = 1'b0;
    rdy4 = 1'b1;
    cyc = 0;
    while (!done4 && cyc < 20) begin
      if (val4) dump4[bin4] = int'(cnt4);
      step();
      cyc++;
    end
    rdy4 = 1'b0;
    check("f5_done", int'(done4), 1);
    check("f5_cycles", cyc, 8);
    check_table(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
